// File: rtl/dispense_actuator.sv
// dispense_actuator
//
// Drives one ingredient valve of the coffee machine for a step requested by
// the sequencer. The step duration is looked up from a recipe table in
// dispense ticks; a prescaler divides clk into ticks of TICK_DIV cycles.
//
// Optional feature (compile-time macro): DISPENSE_DRIP_DELAY_EN
//   When defined, a DRIP phase of DRIP_TICKS ticks (valve closed, busy high)
//   follows every completed valve opening, before the step is acknowledged.
//
// Parameters
//   TICK_DIV    clk cycles per dispense tick (2..65535)
//   DRIP_TICKS  post-close drip delay in ticks (1..255)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   req         step request (level)
//   step[2:0]   ingredient: 1 water, 2 coffee, 3 milk, 4 sugar, 5 cream, 6 finish
//   coffee_sel  recipe: 0 espresso, 1 latte, 2 cappuccino
//   abort       emergency stop (level)
//   valve[4:0]  one-hot actuator drive (bit0 water .. bit4 cream)
//   busy        high whenever the FSM is not in IDLE
//   ack         one-cycle pulse when an accepted step completes
//   err         one-cycle pulse on an invalid request or an abort
//   remaining   ticks left in the OPEN or DRIP phase, 0 otherwise
//   dbg_state   current FSM state (debug)
//   dbg_step    latched step code (debug)
//   dbg_sel     latched recipe code (debug)
//
// Handshake: a request is taken when req=1 and abort=0 are sampled in IDLE.
// Exactly one ack or one err pulse answers every taken request (unless reset
// intervenes). A new request is only taken after req has been seen low.

module dispense_actuator #(
  parameter int TICK_DIV   = 50000,
  parameter int DRIP_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] step,
  input  logic [1:0] coffee_sel,
  input  logic       abort,
  output logic [4:0] valve,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic [7:0] remaining,
  output logic [2:0] dbg_state,
  output logic [2:0] dbg_step,
  output logic [1:0] dbg_sel
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPEN     = 3'd1,
    S_DRIP     = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_LOW = 3'd4
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DRIP_LEN  = 8'(DRIP_TICKS);

  state_t      state, state_d;
  logic [15:0] presc, presc_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  sel_q, sel_d;
  logic [4:0]  valve_d;
  logic        busy_d, ack_d, err_d;
  logic [7:0]  rem_d;
  logic        tick;
  logic [7:0]  dur_in;
  logic        bad_req;

  // Recipe table in ticks. Recipe code 3 never reaches here (rejected first).
  function automatic logic [7:0] duration(input logic [2:0] s, input logic [1:0] c);
    logic [7:0] d;
    d = 8'd0;
    case (s)
      3'd1: d = (c == 2'd0) ? 8'd30 : 8'd20;
      3'd2: d = 8'd20;
      3'd3: d = (c == 2'd1) ? 8'd40 : (c == 2'd2) ? 8'd20 : 8'd0;
      3'd4: d = 8'd10;
      3'd5: d = (c == 2'd2) ? 8'd30 : 8'd0;
      default: d = 8'd0;
    endcase
    return d;
  endfunction

  assign tick    = (presc == TICK_LAST);
  assign dur_in  = duration(step, coffee_sel);
  assign bad_req = (step == 3'd0) || (step == 3'd7) || (coffee_sel == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      presc     <= '0;
      step_q    <= '0;
      sel_q     <= '0;
      valve     <= '0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_d;
      presc     <= presc_d;
      step_q    <= step_d;
      sel_q     <= sel_d;
      valve     <= valve_d;
      busy      <= busy_d;
      ack       <= ack_d;
      err       <= err_d;
      remaining <= rem_d;
    end
  end

  // Next-state and next-output logic. Every output is computed here for the
  // following cycle and registered above, so the valve closes on the same
  // edge that the last tick is counted.
  always_comb begin
    state_d = state;
    presc_d = presc;
    step_d  = step_q;
    sel_d   = sel_q;
    valve_d = valve;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rem_d   = remaining;

    case (state)
      S_IDLE: begin
        valve_d = '0;
        rem_d   = '0;
        presc_d = '0;
        // abort has priority: a request seen together with abort is ignored.
        if (req && !abort) begin
          step_d = step;
          sel_d  = coffee_sel;
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = S_WAIT_LOW;
          end else if (step == 3'd6 || dur_in == 8'd0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = dur_in;
            valve_d = 5'd1 << (step - 3'd1);
            state_d = S_OPEN;
          end
        end
      end

      S_OPEN: begin
        presc_d = tick ? 16'd0 : presc + 16'd1;
        if (abort) begin
          valve_d = '0;
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = S_WAIT_LOW;
        end else if (tick) begin
          if (remaining == 8'd1) begin
            valve_d = '0;
`ifdef DISPENSE_DRIP_DELAY_EN
            rem_d   = DRIP_LEN;
            state_d = S_DRIP;
`else
            rem_d   = '0;
            state_d = S_DONE;
`endif
          end else begin
            rem_d = remaining - 8'd1;
          end
        end
      end

      S_DRIP: begin
        valve_d = '0;
`ifdef DISPENSE_DRIP_DELAY_EN
        presc_d = tick ? 16'd0 : presc + 16'd1;
        if (abort) begin
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = S_WAIT_LOW;
        end else if (tick) begin
          rem_d = remaining - 8'd1;
          if (remaining == 8'd1) state_d = S_DONE;
        end
`else
        // Not reachable in this build; recover to IDLE if ever entered.
        presc_d = '0;
        rem_d   = '0;
        state_d = S_IDLE;
`endif
      end

      S_DONE: begin
        valve_d = '0;
        rem_d   = '0;
        presc_d = '0;
        ack_d   = 1'b1;
        state_d = S_WAIT_LOW;
      end

      S_WAIT_LOW: begin
        valve_d = '0;
        rem_d   = '0;
        presc_d = '0;
        if (!req) state_d = S_IDLE;
      end

      default: begin
        valve_d = '0;
        rem_d   = '0;
        presc_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    if (DRIP_LEN == 8'd0) busy_d = busy_d; // DRIP_LEN is only consumed by the drip build
  end

  assign dbg_state = state;
  assign dbg_step  = step_q;
  assign dbg_sel   = sel_q;

endmodule

// File: tb/tb_dispense_actuator.sv
module tb_dispense_actuator;

  localparam int TD = 4;
  localparam int DT = 2;
  localparam int W  = 44;

  logic       clk = 1'b0;
  logic       reset, req, abort;
  logic [2:0] step;
  logic [1:0] coffee_sel;
  logic [4:0] valve;
  logic       busy, ack, err;
  logic [7:0] remaining;
  logic [2:0] dbg_state, dbg_step;
  logic [1:0] dbg_sel;

  dispense_actuator #(.TICK_DIV(TD), .DRIP_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .req(req), .step(step), .coffee_sel(coffee_sel),
    .abort(abort), .valve(valve), .busy(busy), .ack(ack), .err(err),
    .remaining(remaining), .dbg_state(dbg_state), .dbg_step(dbg_step),
    .dbg_sel(dbg_sel)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry: {kind[1:0] = {err,ack}, step[2:0], sel[1:0], valve_bits[4:0],
  //         valve_cycles[15:0], latency_edges[15:0]}
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_rem;

  int         mon_lat;
  int         mon_vcnt;
  logic [4:0] mon_vbits;
  logic       mon_busy_q = 1'b0;
  logic       mon_active = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      mon_busy_q = 1'b0;
      mon_active = 1'b0;
    end else begin
      check_eq("valve_onehot0", $onehot0(valve), 1'b1);
      if (busy && !mon_busy_q) begin
        check_eq("spurious_accept", (exp_q.size() == 0), 1'b0);
        check_eq("remaining_load", remaining, exp_rem);
        mon_lat    = 0;
        mon_vcnt   = 0;
        mon_vbits  = '0;
        mon_active = 1'b1;
      end else begin
        mon_lat++;
      end
      if (valve != 5'd0) begin
        mon_vcnt++;
        mon_vbits = mon_vbits | valve;
      end
      if (ack || err) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_event", {err, ack}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check_eq("event_kind",   {err, ack}, e[43:42]);
          check_eq("latched_step", dbg_step,   e[41:39]);
          check_eq("latched_sel",  dbg_sel,    e[38:37]);
          check_eq("valve_bits",   mon_vbits,  e[36:32]);
          check_eq("valve_cycles", mon_vcnt,   e[31:16]);
          check_eq("latency",      mon_lat,    e[15:0]);
        end
        mon_active = 1'b0;
      end
      mon_busy_q = busy;
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_dur(input int s, input int c);
    int tbl [1:5][0:2];
    tbl[1] = '{30, 20, 20};
    tbl[2] = '{20, 20, 20};
    tbl[3] = '{ 0, 40, 20};
    tbl[4] = '{10, 10, 10};
    tbl[5] = '{ 0,  0, 30};
    if (s < 1 || s > 5 || c > 2) return 0;
    return tbl[s][c];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Advance one cycle; while the block is busy, scramble step/coffee_sel so
  // that any failure to hold the latched values shows up at the event.
  task automatic cyc_wiggle();
    cyc();
    if (busy) begin
      step       = 3'($urandom_range(0, 7));
      coffee_sel = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      cyc();
      n++;
    end
    if (busy) check_eq("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_req(input int s, input int c, input int abort_k, input int hold);
    logic [1:0]  kind;
    logic [4:0]  vb;
    int          n, vc, lat, d;
    wait_idle();
    d = model_dur(s, c);
    vb = '0;
    vc = 0;
    if (s == 0 || s == 7 || c == 3) begin
      kind = 2'b10; lat = 0; exp_rem = 8'd0;
    end else if (s == 6 || d == 0) begin
      kind = 2'b01; lat = 1; exp_rem = 8'd0;
    end else begin
      exp_rem = 8'(d);
      vb = 5'd1 << (s - 1);
      if (abort_k >= 0) begin
        kind = 2'b10; vc = abort_k + 1; lat = abort_k + 1;
      end else begin
        kind = 2'b01; vc = d * TD;
`ifdef DISPENSE_DRIP_DELAY_EN
        lat = d * TD + DT * TD + 1;
`else
        lat = d * TD + 1;
`endif
      end
    end
    exp_q.push_back({kind, 3'(s), 2'(c), vb, 16'(vc), 16'(lat)});
    req = 1'b1; step = 3'(s); coffee_sel = 2'(c);
    if (abort_k >= 0) begin
      n = 0;
      while (!(mon_active && mon_lat == abort_k) && n < 1000) begin
        cyc_wiggle();
        n++;
      end
      abort = 1'b1;
      cyc_wiggle();
      abort = 1'b0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      cyc_wiggle();
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("event_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (hold) cyc_wiggle();
    if (hold > 0) check_eq("busy_while_req_held", busy, 1'b1);
    req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outputs"}, {valve, busy, ack, err, remaining}, '0);
    check_eq({tag, "_debug"}, {dbg_state, dbg_step, dbg_sel}, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, c, k, n;
    reset = 1'b1; req = 1'b0; abort = 1'b0; step = '0; coffee_sel = '0;
    exp_rem = '0;
    repeat (3) cyc();
    check_all_zero("reset");
    reset = 1'b0;
    cyc();

    // Water espresso: 30 ticks of valve bit0, held req afterwards.
    do_req(1, 0, -1, 3);
    // Zero-duration milk and finish step go straight to ack.
    do_req(3, 0, -1, 0);
    do_req(6, 1, -1, 1);
    // Invalid codes: err, no valve, held req must not re-trigger.
    do_req(7, 0, -1, 6);
    do_req(0, 1, -1, 0);
    do_req(2, 3, -1, 2);
    // Abort 40 cycles into a latte coffee dispense.
    do_req(2, 1, 40, 1);
    do_req(5, 2, -1, 0);
    do_req(4, 1, -1, 0);

    // Abort together with req in IDLE: not accepted, no err.
    wait_idle();
    req = 1'b1; abort = 1'b1; step = 3'd1; coffee_sel = 2'd0;
    repeat (3) begin
      cyc();
      check_eq("abort_idle_busy", busy, 1'b0);
      check_eq("abort_idle_err", err, 1'b0);
    end
    req = 1'b0; abort = 1'b0;
    cyc();

    // Reset 30 cycles into a cream cappuccino dispense.
    wait_idle();
    exp_rem = 8'd30;
    exp_q.push_back('0);
    req = 1'b1; step = 3'd5; coffee_sel = 2'd2;
    n = 0;
    while (!(mon_active && mon_lat == 29) && n < 200) begin
      cyc();
      n++;
    end
    check_eq("mid_open_valve", valve, 5'b10000);
    reset = 1'b1;
    cyc();
    check_all_zero("reset_mid_open");
    exp_q.delete();
    req = 1'b0;
    reset = 1'b0;
    cyc();
    do_req(5, 2, -1, 0);

    // Random requests with occasional aborts.
    for (int i = 0; i < 24; i++) begin
      s = $urandom_range(0, 7);
      c = $urandom_range(0, 3);
      k = -1;
      if (model_dur(s, c) != 0 && $urandom_range(0, 3) == 0)
        k = $urandom_range(0, model_dur(s, c) * TD - 2);
      do_req(s, c, k, $urandom_range(0, 3));
    end

    wait_idle();
    repeat (5) cyc();
    check_eq("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
